// File: rtl/line_clear_sequencer.sv
// Multi-cycle row-clear sequencer: scans a board snapshot bottom-up, drops full rows and
// compacts survivors downward one row per cycle, then presents the result with a done pulse.
module line_clear_sequencer #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BOARD_W*BOARD_H-1:0] board_in,
  output logic                       busy,
  output logic                       done,
  output logic [BOARD_W*BOARD_H-1:0] board_out,
  output logic [CNT_W-1:0]           rows_cleared,
  output logic [BOARD_H-1:0]         clear_mask
);

  localparam int unsigned NCell = BOARD_W * BOARD_H;

  typedef enum logic [1:0] {StIdle, StScan, StFill, StDone} state_e;

  state_e               state_q, state_d;
  logic [NCell-1:0]     wb_q, wb_d;
  logic [CNT_W-1:0]     rd_q, rd_d;
  // One extra bit so the write pointer can sit at -1 when no row was full.
  logic [CNT_W:0]       wr_q, wr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BOARD_H-1:0]   mask_q, mask_d;
  logic [NCell-1:0]     board_out_q, board_out_d;
  logic [CNT_W-1:0]     rows_cleared_q, rows_cleared_d;
  logic [BOARD_H-1:0]   clear_mask_q, clear_mask_d;

  logic [BOARD_W-1:0]   row_cur;
  logic                 row_full;

  always_comb begin
    row_cur = '0;
    for (int r = 0; r < int'(BOARD_H); r++) begin
      if (CNT_W'(r) == rd_q) row_cur = wb_q[r*BOARD_W +: BOARD_W];
    end
    row_full = &row_cur;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (rd_q == '0) state_d = StFill;
      StFill:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_d           = wb_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    board_out_d    = board_out_q;
    rows_cleared_d = rows_cleared_q;
    clear_mask_d   = clear_mask_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          wb_d   = board_in;
          rd_d   = CNT_W'(BOARD_H - 1);
          wr_d   = (CNT_W+1)'(BOARD_H - 1);
          cnt_d  = '0;
          mask_d = '0;
        end
      end
      StScan: begin
        if (row_full) begin
          for (int r = 0; r < int'(BOARD_H); r++) begin
            if (CNT_W'(r) == rd_q) mask_d[r] = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          // wr never trails rd, so the in-place copy never clobbers an unread row.
          for (int r = 0; r < int'(BOARD_H); r++) begin
            if ((CNT_W+1)'(r) == wr_q) wb_d[r*BOARD_W +: BOARD_W] = row_cur;
          end
          wr_d = wr_q - 1'b1;
        end
        if (rd_q != '0) rd_d = rd_q - 1'b1;
      end
      StFill: begin
        if (cnt_q != '0) begin
          for (int r = 0; r < int'(BOARD_H); r++) begin
            if ((CNT_W+1)'(r) <= wr_q) wb_d[r*BOARD_W +: BOARD_W] = '0;
          end
        end
        // Result registers change on the edge into DONE so they are valid alongside done.
        board_out_d    = wb_d;
        rows_cleared_d = cnt_q;
        clear_mask_d   = mask_q;
      end
      StDone: ;
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q == StScan) || (state_q == StFill);
    done         = (state_q == StDone);
    board_out    = board_out_q;
    rows_cleared = rows_cleared_q;
    clear_mask   = clear_mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      wb_q           <= '0;
      rd_q           <= '0;
      wr_q           <= '0;
      cnt_q          <= '0;
      mask_q         <= '0;
      board_out_q    <= '0;
      rows_cleared_q <= '0;
      clear_mask_q   <= '0;
    end else begin
      state_q        <= state_d;
      wb_q           <= wb_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      board_out_q    <= board_out_d;
      rows_cleared_q <= rows_cleared_d;
      clear_mask_q   <= clear_mask_d;
    end
  end

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Scoreboard bench for line_clear_sequencer: a row-list reference model predicts each result
// and its done cycle; a negedge monitor pops and compares whenever done is seen.
module tb_line_clear_sequencer;

  localparam int W     = 10;
  localparam int H     = 20;
  localparam int CNT_W = 5;
  localparam int N     = W * H;

  typedef struct {
    logic [N-1:0]     board;
    logic [CNT_W-1:0] cnt;
    logic [H-1:0]     mask;
    int               done_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [N-1:0]     board_in = '0;
  logic             busy;
  logic             done;
  logic [N-1:0]     board_out;
  logic [CNT_W-1:0] rows_cleared;
  logic [H-1:0]     clear_mask;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int next_ok = 0;
  exp_t sb[$];
  logic [N-1:0]     last_board = '0;
  logic [CNT_W-1:0] last_cnt = '0;
  logic [H-1:0]     last_mask = '0;

  line_clear_sequencer #(.BOARD_W(W), .BOARD_H(H), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .board_in     (board_in),
    .busy         (busy),
    .done         (done),
    .board_out    (board_out),
    .rows_cleared (rows_cleared),
    .clear_mask   (clear_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Full rows vanish; surviving rows keep their order and stack from the bottom.
  function automatic exp_t model(input logic [N-1:0] b);
    exp_t e;
    logic [W-1:0] keep[$];
    logic [W-1:0] row;
    e.board = '0; e.cnt = '0; e.mask = '0; e.done_cyc = 0;
    for (int r = H - 1; r >= 0; r--) begin
      row = b[r*W +: W];
      if (row == {W{1'b1}}) begin
        e.mask[r] = 1'b1;
        e.cnt = e.cnt + 1'b1;
      end else begin
        keep.push_back(row);
      end
    end
    for (int i = 0; i < keep.size(); i++) e.board[(H-1-i)*W +: W] = keep[i];
    return e;
  endfunction

  function automatic logic [N-1:0] rand_board(input int full_pct);
    logic [N-1:0] b;
    logic [W-1:0] row;
    b = '0;
    for (int r = 0; r < H; r++) begin
      if (int'($urandom_range(99)) < full_pct) row = {W{1'b1}};
      else begin
        row = W'($urandom);
        if (row == {W{1'b1}}) row[$urandom_range(W-1)] = 1'b0;
      end
      b[r*W +: W] = row;
    end
    return b;
  endfunction

  // Called just after a rising edge; the start is sampled on the next edge (index cyc+1).
  task automatic drive_start(input logic [N-1:0] b);
    exp_t e;
    start = 1'b1;
    board_in = b;
    if (cyc + 1 >= next_ok) begin
      e = model(b);
      e.done_cyc = cyc + 1 + H + 1;
      sb.push_back(e);
      next_ok = cyc + 1 + H + 3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    board_in = rand_board(30);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    last_board = '0; last_cnt = '0; last_mask = '0;
    next_ok = cyc + 1;
    check("reset_busy", N'(busy), '0);
    check("reset_done", N'(done), '0);
    check("reset_board_out", board_out, '0);
    check("reset_rows_cleared", N'(rows_cleared), '0);
    check("reset_clear_mask", N'(clear_mask), '0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", N'(cyc), N'(e.done_cyc));
          check("board_out", board_out, e.board);
          check("rows_cleared", N'(rows_cleared), N'(e.cnt));
          check("clear_mask", N'(clear_mask), N'(e.mask));
          last_board = e.board; last_cnt = e.cnt; last_mask = e.mask;
        end
      end else begin
        check("held_board_out", board_out, last_board);
        check("held_rows_cleared", N'(rows_cleared), N'(last_cnt));
        check("held_clear_mask", N'(clear_mask), N'(last_mask));
      end
      if (sb.size() > 0 && cyc >= sb[0].done_cyc - H - 1 && cyc < sb[0].done_cyc)
        check("busy", N'(busy), N'(1));
      else
        check("busy", N'(busy), N'(0));
    end
  end

  initial begin
    logic [N-1:0] b;
    int a;
    int t;

    do_reset(3);

    // Empty board, then the directed patterns.
    wait_until(next_ok - 1); drive_start('0);
    b = '0; b[199:190] = '1; b[185] = 1'b1;
    wait_until(next_ok - 1); drive_start(b);
    b = '0; b[199:190] = '1; b[179:170] = '1; b[180] = 1'b1;
    wait_until(next_ok - 1); drive_start(b);
    b = '0; b[199:160] = '1; b[150] = 1'b1;
    wait_until(next_ok - 1); drive_start(b);
    wait_until(next_ok - 1); drive_start('1);

    // Starts while busy and on the done cycle are dropped; the next one is accepted.
    wait_until(next_ok - 1);
    a = cyc + 1;
    drive_start(rand_board(40));
    wait_until(a + 4);  drive_start(rand_board(40));
    wait_until(a + 21); drive_start(rand_board(40));
    drive_start(rand_board(40));

    // Reset in the middle of a scan: no done for that op, outputs cleared.
    wait_until(next_ok - 1);
    a = cyc + 1;
    drive_start(rand_board(50));
    wait_until(a + 9);
    do_reset(1);
    drive_start(rand_board(50));

    // Random boards, back-to-back and with idle gaps.
    for (int i = 0; i < 25; i++) begin
      wait_until(next_ok - 1 + int'($urandom_range(3)));
      drive_start(rand_board(int'($urandom_range(70))));
    end

    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/line_clear_sequencer.md
# line_clear_sequencer

Multi-cycle controller that takes a settled board snapshot, finds every complete row, and compacts the board by shifting the surviving rows downward one row per cycle. It sits between the piece-lock logic and the main game register: the game FSM pulses `start` with the locked board, waits for `done`, then loads `board_out` into the stacked-block register. It forwards `rows_cleared` to score control. It replaces the single-cycle combinational row collapse with a bounded, timing-friendly sequence.

## Interface
- `BOARD_W`, default 10, cells per row.
- `BOARD_H`, default 20, rows per board.
- `CNT_W`, default 5, width of the row counters; must satisfy 2^CNT_W > BOARD_H.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `board_in`  in  BOARD_W*BOARD_H  board snapshot; bit 0 is top-left, row r occupies bits [r*BOARD_W +: BOARD_W], row BOARD_H-1 is the bottom.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `board_out`  out  BOARD_W*BOARD_H  compacted board; updated only on the `done` cycle and held otherwise.
- `rows_cleared`  out  CNT_W  number of full rows removed; updated on `done` and held.
- `clear_mask`  out  BOARD_H  bit r set if original row r was full; updated on `done` and held.

One clock and one reset. Reset is synchronous and active-high.

## Operation
**Reset.** On any edge with `rst`=1, all state and outputs clear: state=IDLE, `busy`=0, `done`=0, `board_out`=0, `rows_cleared`=0, `clear_mask`=0, working registers=0. Reset overrides `start` and aborts any operation in progress with no partial output.

**States.**
- **IDLE.** `busy`=0. If `start`=1:
  - latch `board_in` into working register `wb`;
  - set `rd`=`wr`=BOARD_H-1, `cnt`=0, `mask`=0;
  - go to SCAN.
- **SCAN.** Each cycle processes row `rd`:
  - If every bit of `wb` row `rd` is 1: set `mask[rd]`, `cnt`+1, `wr` unchanged.
  - Otherwise: copy `wb` row `rd` into `wb` row `wr`, then `wr`-1. The copy is a no-op when `rd`==`wr`.
  - If `rd`==0: go to FILL. Otherwise `rd`-1.
  - In-place copy is safe because `wr`≥`rd` always holds.
- **FILL.** In one cycle, zero all rows 0..`wr` of `wb`, but only if `cnt`>0. When `cnt`=0, `wr` has underflowed and the board is left unchanged. Go to DONE.
- **DONE.** `done`=1 and `busy`=0 for exactly this cycle. Load `board_out`←`wb`, `rows_cleared`←`cnt`, `clear_mask`←`mask`. Go to IDLE.

**Counter rules.**
- `wr` is CNT_W+1 bits wide so it can represent -1 when no row is full.
- `cnt` saturates naturally at BOARD_H. If all rows are full, `rows_cleared`=BOARD_H and `board_out`=0.

**Input handling.**
- `start` in SCAN, FILL or DONE is ignored and is not queued.
- `board_in` is sampled only on the accepting edge; later changes have no effect.

## Timing
- Let `start` be sampled high in IDLE at edge E0.
- `busy`=1 from E0 through the SCAN and FILL cycles.
- SCAN spans BOARD_H cycles; FILL is 1 cycle.
- `done` is high in the cycle following edge E0+BOARD_H+1, i.e. BOARD_H+2 cycles after E0. With defaults: start at cycle 0 gives `done` at cycle 22.
- Back-to-back operation: `start` may be asserted in the cycle `done` is high. It is not accepted, because state is DONE. The earliest accepted restart is the following cycle, giving a throughput of one operation per BOARD_H+3 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold `rst` 3 cycles, release → `busy`=0, `done`=0, `board_out`=0, `rows_cleared`=0, `clear_mask`=0. Then start with an empty board → `done` at cycle 22, `rows_cleared`=0, `board_out`=0.
- **Single bottom row:** bits 190..199 set plus bit 185 (row 18, col 5); start → `done` at cycle 22, `rows_cleared`=1, `clear_mask`=20'h80000, `board_out` has only bit 195 set.
- **Two non-adjacent rows:** rows 19 and 17 full, row 18 = 10'b0000000001 (bit 180); start → `rows_cleared`=2, `clear_mask` bits 17 and 19 set, `board_out` has only bit 190 set.
- **Tetris plus debris:** rows 16..19 full, row 15 = bit 150 only; start → `rows_cleared`=4, `board_out` has only bit 190 set, rows 0..18 zero.
- **Start while busy:** pulse `start` at cycles 0, 5 and 22 with different boards → one `done` at cycle 22 reflecting the cycle-0 board; the next accepted start is at cycle ≥23, with its `done` 22 cycles after acceptance.
- **Reset mid-operation:** assert `rst` at cycle 10 of SCAN → next cycle `busy`=0, no `done` pulse ever appears, previous `board_out` cleared to 0. A new start completes normally.
